// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared constants and helpers for the IF/ID decoupling queue.
//   ENABLE/DISABLE   - single-bit control levels
//   IFQ_PRED         - 1 when the IFQ_PRED_EN macro is defined, i.e. entries
//                      carry the branch-prediction fields
//   ifq_entry_w()    - storage width of one queue entry
package if_id_queue_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

`ifdef IFQ_PRED_EN
  localparam bit IFQ_PRED = 1'b1;
`else
  localparam bit IFQ_PRED = 1'b0;
`endif

  // Entry layout, LSB first: inst, pc, then (optionally) pred, pred_target.
  function automatic int ifq_entry_w(int addr_w, int inst_w, bit pred_en);
    return addr_w + inst_w + (pred_en ? addr_w + 1 : 0);
  endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// ifq_mem: storage array for the IF/ID queue.
//   clk          - clock
//   we/waddr/wdata - single write port, written on the rising edge
//   raddr/rdata  - asynchronous read port (head entry lookup)
// Contents are not reset; validity is tracked by the queue pointers.
module ifq_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: in-order fetch/decode decoupling queue replacing the IF/ID
// register. IF pushes {pc, inst[, pred, pred_target]}; ID pops over a
// valid/ready handshake. EX flush discards every entry.
//   clk, rst (sync, active-high), flush
//   if_valid/if_ready/if_pc/if_inst/if_pred/if_pred_target - IF side
//   id_valid/id_ready/id_pc/id_inst/id_pred/id_pred_target - ID side (head)
//   count - occupancy
// Build option: define IFQ_PRED_EN to store and present prediction fields;
// otherwise they are dropped and id_pred/id_pred_target read 0.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [ADDR_W-1:0]        if_pc,
  input  logic [INST_W-1:0]        if_inst,
  input  logic                     if_pred,
  input  logic [ADDR_W-1:0]        if_pred_target,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [INST_W-1:0]        id_inst,
  output logic                     id_pred,
  output logic [ADDR_W-1:0]        id_pred_target,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;   // extra MSB is the wrap bit
  localparam int EW = ifq_entry_w(ADDR_W, INST_W, IFQ_PRED);

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          empty, full, push, pop;
  logic [EW-1:0] wdata, rdata;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);

  // if_ready looks only at our own state, so no IF<->ID combinational path;
  // a pop while full therefore cannot make room for a push in the same cycle.
  assign if_ready = !full;
  assign id_valid = !empty;
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & id_ready;
  assign count    = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

`ifdef IFQ_PRED_EN
  assign wdata = {if_pred_target, if_pred, if_pc, if_inst};
`else
  assign wdata = {if_pc, if_inst};
  logic unused_pred;
  assign unused_pred = ^{if_pred, if_pred_target};
`endif

  ifq_mem #(.DEPTH(DEPTH), .WIDTH(EW)) u_mem (
    .clk   (clk),
    .we    (push & ~flush & ~rst),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  // Head outputs read zero while empty so ID never sees stale storage.
  always_comb begin
    id_inst        = '0;
    id_pc          = '0;
    id_pred        = DISABLE;
    id_pred_target = '0;
    if (id_valid) begin
      id_inst = rdata[INST_W-1:0];
      id_pc   = rdata[INST_W +: ADDR_W];
`ifdef IFQ_PRED_EN
      id_pred        = rdata[INST_W+ADDR_W];
      id_pred_target = rdata[INST_W+ADDR_W+1 +: ADDR_W];
`endif
    end
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised fetch/decode decoupling queue that replaces the single-entry IF/ID pipeline register. Holds up to DEPTH fetched instructions with their PC and branch-prediction info, and presents them in order to ID over a valid/ready handshake. Sits between the IF stage and the ID stage. It is flushed by EX on a branch redirect, so IF can keep fetching while ID stalls.

## Interface
- ADDR_W, 32, PC width
- INST_W, 32, instruction width
- DEPTH, 4, entry count; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  branch redirect from EX; discards all entries
- if_valid  in  1  IF presents an instruction
- if_ready  out  1  queue can accept this cycle
- if_pc  in  ADDR_W  fetch PC
- if_inst  in  INST_W  fetched instruction
- if_pred  in  1  predictor taken bit
- if_pred_target  in  ADDR_W  predicted target
- id_valid  out  1  head entry valid
- id_ready  in  1  ID consumes head this cycle (0 = ID stalled)
- id_pc  out  ADDR_W  head PC
- id_inst  out  INST_W  head instruction
- id_pred  out  1  head prediction bit
- id_pred_target  out  ADDR_W  head predicted target
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Circular buffer with rd_ptr/wr_ptr, each $clog2(DEPTH)+1 bits.
  - MSB is the wrap bit.
  - Empty: pointers equal. Full: low bits equal, MSBs differ.
- push = if_valid & if_ready; pop = id_valid & id_ready.
- if_ready = !full.
  - Does not depend on id_ready, so there is no combinational IF↔ID path.
  - When full, a simultaneous pop does not admit a push that cycle.
- Push: entry[wr_ptr] ← {if_pc, if_inst, if_pred, if_pred_target}; wr_ptr+1.
- Pop: rd_ptr+1.
- Simultaneous push and pop (non-full, non-empty): count unchanged; both pointers advance.
- Simultaneous push and pop when empty: not possible, because id_valid=0.
- Head outputs are driven combinationally from entry[rd_ptr].
  - When empty: id_valid=0, and id_pc/id_inst/id_pred_target = 0, id_pred = 0.
- Flush has priority over push and pop.
  - Next cycle: rd_ptr = wr_ptr = 0, count = 0.
  - An instruction offered in the flush cycle is dropped.
  - The pop in the flush cycle is ignored by the queue; ID must also discard its own stage.
- Pointers wrap modulo 2·DEPTH; the entry index is the low bits.

## Timing
- Reset values:
  - rd_ptr = wr_ptr = 0, count = 0.
  - if_ready = 1, id_valid = 0.
  - All id_* data outputs = 0.
  - Storage contents don't-care.
- Latency: an entry pushed at edge N is visible on id_* after edge N (cycle N+1) at the earliest. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained.
- Flush asserted in cycle N: if_ready = 1 and id_valid = 0 in cycle N+1.
- Reset mid-operation behaves like flush and also zeroes the pointers; the occupancy is lost.
- Stalled ID (id_ready=0) with IF pushing: count rises by 1 per cycle until DEPTH, then if_ready = 0.

## Configuration
- IFQ_PRED_EN defined:
  - Entries store if_pred and if_pred_target.
  - id_pred and id_pred_target follow the head entry.
- IFQ_PRED_EN undefined:
  - Prediction fields are not stored.
  - if_pred and if_pred_target are ignored.
  - id_pred = 0 and id_pred_target = 0 constantly.
  - Storage width is ADDR_W+INST_W per entry.

## Structure
- The shared defines file provides Enable/Disable, ZeroWord, InstAddrBus and InstBus.
- Queue-specific width macros are derived from the parameters locally; none are added to the shared file.
- One sub-module, ifq_mem:
  - Storage array of DEPTH entries.
  - One write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- Pointer, count and flush logic live in if_id_queue.

## Test plan
- Reset, then idle → if_ready=1, id_valid=0, count=0, id_pc=0, id_inst=0.
- Push pc 0x00,0x04,0x08,0x0C with id_ready=0 (DEPTH=4) → count=4, if_ready=0. A fifth if_valid is not accepted. id_pc=0x00 throughout.
- From full, id_ready=1 for 4 cycles with if_valid=0 → id_pc sequence 0x00,0x04,0x08,0x0C, then id_valid=0 and count=0.
- Continuous push and pop for 10 cycles, pc 0x100 upward by 4 → pointers wrap. id_pc follows one cycle behind if_pc with no gaps; count stays 1.
- With 3 entries queued, assert flush together with if_valid (pc 0x200) → next cycle count=0, id_valid=0. 0x200 never appears on id_pc.
- With IFQ_PRED_EN, push pc 0x10 with pred=1, target 0x80 → head shows id_pred=1, id_pred_target=0x80. Without the macro → id_pred=0, id_pred_target=0.
